// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache miss/refill path:
//   - geometry constants (tag/index/offset widths, line and memory beat widths)
//   - refill controller state encoding
//   - address field helpers (tag/index extraction, line-aligned address build)
// Optional feature macro: CACHE_WRITEBACK_EN adds the writeback states.
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int TAG_W    = 23;
  localparam int IDX_W    = 6;
  localparam int OFFSET_W = 3;
  localparam int LINE_W   = 64;
  localparam int MEM_W    = 16;
  localparam int BEATS    = LINE_W / MEM_W;
  localparam int CNT_W    = $clog2(BEATS);

  // Writeback states exist only in a write-back build; the write-through
  // build never encodes them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
`ifdef CACHE_WRITEBACK_EN
    ST_WB_REQ  = 3'd4,
    ST_WB_DATA = 3'd5,
`endif
    ST_FILL    = 3'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/line_beat_shifter.sv
// -----------------------------------------------------------------------------
// line_beat_shifter
// One cache line register shared by writeback serialization and refill
// assembly. Beat 0 occupies the least significant MEM_W bits.
// Ports:
//   clk, rst_n    clock, async active-low reset (clears the line)
//   i_load        parallel load of i_load_data (victim line capture)
//   i_load_data   full line to load
//   i_wr_en       write i_wr_beat into slot i_beat_idx (refill); load wins
//   i_beat_idx    beat slot for both read and write
//   i_wr_beat     incoming refill beat
//   o_rd_beat     beat at slot i_beat_idx (writeback data)
//   o_line        whole line (fill data)
// -----------------------------------------------------------------------------
module line_beat_shifter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_load_data,
  input  logic              i_wr_en,
  input  logic [CNT_W-1:0]  i_beat_idx,
  input  logic [MEM_W-1:0]  i_wr_beat,
  output logic [MEM_W-1:0]  o_rd_beat,
  output logic [LINE_W-1:0] o_line
);

  logic [LINE_W-1:0] r_line;

  // NOTE: the line is a plain register, not an array macro, so it is reset
  // here; that keeps fill_data/mem_wdata at zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_data;
    end else if (i_wr_en) begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop
      // samples pre-edge values regardless of statement order.
      for (int b = 0; b < BEATS; b++) begin
        if (i_beat_idx == CNT_W'(b)) r_line[b*MEM_W +: MEM_W] <= i_wr_beat;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves the output unassigned (no latch).
    o_rd_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (i_beat_idx == CNT_W'(b)) o_rd_beat = r_line[b*MEM_W +: MEM_W];
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Miss-side controller for a 2-way, 64-set cache with 64-bit lines. On an
// accepted miss it optionally writes back a dirty victim, reads the missing
// line as BEATS serial beats, then issues a single-cycle array fill.
// Optional feature macro: CACHE_WRITEBACK_EN (dirty-victim writeback). When
// undefined the cache is write-through: victim_dirty/victim_data are ignored
// and the mem_w* channel is tied off.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   miss_valid/miss_ready          miss handshake; miss_addr {tag,index,offset}
//   victim_way/valid/dirty/tag/data victim state, sampled at miss acceptance
//   mem_req_valid/ready/we/addr    memory request (line-aligned address)
//   mem_wdata/wvalid/wready        writeback beat channel
//   mem_rdata/mem_rvalid           read beat channel (no backpressure)
//   fill_we/way/index/tag/data/dirty  one-cycle array fill
//   busy                           controller not idle
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_we,
  output logic              fill_way,
  output logic [IDX_W-1:0]  fill_index,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_dirty,
  output logic              busy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_index;
  logic              r_way;

  logic              w_accept;
  logic              w_cnt_last;
  logic              w_beat_wr;
  logic              w_wb_step;
  logic              w_load;
  logic [MEM_W-1:0]  w_rd_beat;
  logic [LINE_W-1:0] w_line;
  logic              w_unused;

  assign w_accept   = (r_state == ST_IDLE) && miss_valid;
  assign w_cnt_last = (r_cnt == CNT_W'(BEATS - 1));
  assign w_beat_wr  = (r_state == ST_RD_DATA) && mem_rvalid;

`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0] r_vtag;

  // The victim line is loaded on every acceptance; a clean miss simply
  // overwrites it with refill beats.
  assign w_load    = w_accept;
  assign w_wb_step = (r_state == ST_WB_DATA) && mem_wready;
  assign w_unused  = ^miss_addr[OFFSET_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_vtag <= '0;
    else if (w_accept) r_vtag <= victim_tag;
  end
`else
  assign w_load    = 1'b0;
  assign w_wb_step = 1'b0;
  assign w_unused  = ^{miss_addr[OFFSET_W-1:0], victim_valid, victim_dirty,
                       victim_tag, victim_data, mem_wready, w_rd_beat};
`endif

  line_beat_shifter u_line (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_data (victim_data),
    .i_wr_en     (w_beat_wr),
    .i_beat_idx  (r_cnt),
    .i_wr_beat   (mem_rdata),
    .o_rd_beat   (w_rd_beat),
    .o_line      (w_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Shared beat counter; the last beat of either phase returns it to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_beat_wr || w_wb_step) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag   <= '0;
      r_index <= '0;
      r_way   <= 1'b0;
    end else if (w_accept) begin
      r_tag   <= addr_tag(miss_addr);
      r_index <= addr_index(miss_addr);
      r_way   <= victim_way;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    fill_we       = 1'b0;
    fill_way      = 1'b0;
    fill_index    = '0;
    fill_tag      = '0;
    fill_data     = '0;

    case (r_state)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
`ifdef CACHE_WRITEBACK_EN
          w_state_nxt = (victim_valid && victim_dirty) ? ST_WB_REQ : ST_RD_REQ;
`else
          w_state_nxt = ST_RD_REQ;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      ST_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = line_addr(r_vtag, r_index);
        if (mem_req_ready) w_state_nxt = ST_WB_DATA;
      end
      ST_WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = w_rd_beat;
        if (mem_wready && w_cnt_last) w_state_nxt = ST_RD_REQ;
      end
`endif
      ST_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = line_addr(r_tag, r_index);
        if (mem_req_ready) w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (mem_rvalid && w_cnt_last) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        fill_we     = 1'b1;
        fill_way    = r_way;
        fill_index  = r_index;
        fill_tag    = r_tag;
        fill_data   = w_line;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fill_dirty = 1'b0;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Scoreboard bench for cache_refill_ctrl. Each miss pushes its expected memory
// requests, writeback beats and fill onto a queue; a negedge monitor pops and
// compares whenever the DUT produces one of those events. Expectations follow
// the CACHE_WRITEBACK_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;
  import cache_pkg::*;

`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_BUILD   = 1'b1;
  localparam int DIRTY_FILL = 11;
`else
  localparam bit WB_BUILD   = 1'b0;
  localparam int DIRTY_FILL = 6;
`endif
  localparam int CLEAN_FILL = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              miss_valid, miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic              victim_way, victim_valid, victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_data;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;
  logic              mem_wvalid, mem_wready, mem_rvalid;
  logic              fill_we, fill_way, fill_dirty, busy;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic [LINE_W-1:0] fill_data;

  cache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data), .fill_dirty(fill_dirty),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_REQ, EV_WBEAT, EV_FILL} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [63:0] a;
    logic [63:0] b;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Values driven onto the miss port while the previous miss is still busy.
  logic [ADDR_W-1:0] nx_addr;
  logic              nx_way, nx_valid, nx_dirty;
  logic [TAG_W-1:0]  nx_vtag;
  logic [LINE_W-1:0] nx_vdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_pop(input ev_kind_e k, input logic [63:0] a, input logic [63:0] b);
    sb_item_t it;
    check("sb_avail", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check("ev_kind", 64'(it.kind), 64'(k));
      case (k)
        EV_REQ:   check("mem_req", a, it.a);
        EV_WBEAT: check("wbeat", a, it.a);
        default: begin
          check("fill_meta", a, it.a);
          check("fill_data", b, it.b);
        end
      endcase
    end
  endtask

  // Negedge monitor: scoreboard pops plus hold-until-accepted checks.
  logic        p_req_pend = 1'b0, p_w_pend = 1'b0;
  logic [32:0] p_req;
  logic [15:0] p_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_req_pend <= 1'b0;
      p_w_pend   <= 1'b0;
    end else begin
      if (p_req_pend)
        check("req_hold", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'({1'b1, p_req}));
      if (p_w_pend)
        check("wbeat_hold", 64'({mem_wvalid, mem_wdata}), 64'({1'b1, p_wdata}));
`ifndef CACHE_WRITEBACK_EN
      check("wchan_idle", 64'({mem_wvalid, mem_wdata}), 64'd0);
`endif
      if (mem_req_valid && mem_req_ready)
        sb_pop(EV_REQ, {31'd0, mem_req_we, mem_req_addr}, 64'd0);
      if (mem_wvalid && mem_wready)
        sb_pop(EV_WBEAT, {48'd0, mem_wdata}, 64'd0);
      if (fill_we)
        sb_pop(EV_FILL, {33'd0, fill_way, fill_index, fill_tag, fill_dirty}, fill_data);
      p_req_pend <= mem_req_valid && !mem_req_ready;
      p_req      <= {mem_req_we, mem_req_addr};
      p_w_pend   <= mem_wvalid && !mem_wready;
      p_wdata    <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [31:0] addr, input logic way, input logic vvalid,
                             input logic vdirty, input logic [TAG_W-1:0] vtag,
                             input logic [63:0] vdata, input logic [63:0] rline);
    logic [22:0] tag;
    logic [5:0]  idx;
    tag = addr[31:9];
    idx = addr[8:3];
    if (WB_BUILD && vvalid && vdirty) begin
      sb_q.push_back('{EV_REQ, {31'd0, 1'b1, vtag, idx, 3'b000}, 64'd0});
      for (int i = 0; i < 4; i++) sb_q.push_back('{EV_WBEAT, {48'd0, vdata[16*i +: 16]}, 64'd0});
    end
    sb_q.push_back('{EV_REQ, {31'd0, 1'b0, tag, idx, 3'b000}, 64'd0});
    sb_q.push_back('{EV_FILL, {33'd0, way, idx, tag, 1'b0}, rline});
  endtask

  // One complete miss. The caller's current cycle is cycle 0 (acceptance).
  task automatic run_miss(input logic [31:0] addr, input logic way, input logic vvalid,
                          input logic vdirty, input logic [TAG_W-1:0] vtag,
                          input logic [63:0] vdata, input logic [63:0] rline,
                          input int req_stall, input bit wtoggle, input bit rgap,
                          input bit hold_next, input int exp_fill);
    int  fill_cyc = -1;
    int  sent     = 0;
    int  stall    = 0;
    bit  rd_go    = 0;
    bit  done     = 0;
    push_expect(addr, way, vvalid, vdirty, vtag, vdata, rline);
    check("ready_c0", 64'(miss_ready), 64'd1);
    miss_valid = 1'b1; miss_addr = addr; victim_way = way;
    victim_valid = vvalid; victim_dirty = vdirty; victim_tag = vtag; victim_data = vdata;
    for (int n = 1; n <= 300 && !done; n++) begin
      step();
      if (n == 1) begin
        if (hold_next) begin
          miss_addr = nx_addr; victim_way = nx_way; victim_valid = nx_valid;
          victim_dirty = nx_dirty; victim_tag = nx_vtag; victim_data = nx_vdata;
        end else begin
          miss_valid = 1'b0; miss_addr = $urandom; victim_way = ~way;
          victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = TAG_W'($urandom);
          victim_data = {$urandom, $urandom};
        end
      end
      if (fill_cyc >= 0) begin
        check("fill_one_cycle", 64'(fill_we), 64'd0);
        check("ready_after_fill", 64'(miss_ready), 64'd1);
        check("idle_after_fill", 64'(busy), 64'd0);
        done = 1;
      end else begin
        check("ready_while_busy", 64'(miss_ready), 64'd0);
        if (fill_we) begin
          fill_cyc = n;
          if (exp_fill >= 0) check("fill_cycle", 64'(n), 64'(exp_fill));
        end
        if (rd_go && sent < 4 && (!rgap || (n % 2) == 0)) begin
          mem_rvalid = 1'b1; mem_rdata = rline[16*sent +: 16]; sent++;
        end else begin
          mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
        end
        mem_req_ready = 1'b0;
        if (mem_req_valid) begin
          if (stall >= req_stall) begin
            mem_req_ready = 1'b1; stall = 0;
            if (!mem_req_we) rd_go = 1;
          end else begin
            stall++;
          end
        end
        mem_wready = wtoggle ? 1'((n % 2) == 1) : 1'b1;
      end
    end
    mem_rvalid = 1'b0; mem_req_ready = 1'b0; mem_wready = 1'b1;
    check("fill_seen", 64'(fill_cyc >= 0), 64'd1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; miss_valid = 1'b0; miss_addr = '0; victim_way = 1'b0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0; victim_data = '0;
    mem_req_ready = 1'b0; mem_wready = 1'b1; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss_ready", 64'(miss_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'd0);
    check("rst_wchan", 64'({mem_wvalid, mem_wdata}), 64'd0);
    check("rst_fill", 64'({fill_we, fill_way, fill_index, fill_tag, fill_dirty}), 64'd0);
    check("rst_fill_data", fill_data, 64'd0);
    rst_n = 1'b1;
    step();

    // Clean miss from the reference vector.
    run_miss(32'h0000_1A48, 1'b1, 1'b0, 1'b0, 23'h0, 64'h0,
             64'h4444_3333_2222_1111, 0, 0, 0, 0, CLEAN_FILL);

    // Dirty victim, same miss.
    run_miss(32'h0000_1A48, 1'b1, 1'b1, 1'b1, 23'h00002A, 64'hDEAD_BEEF_0123_4567,
             64'h4444_3333_2222_1111, 0, 0, 0, 0, DIRTY_FILL);

    // Backpressure: request stalls, toggling wready, gapped read beats.
    run_miss(32'h0012_3478, 1'b0, 1'b1, 1'b1, 23'h12ABC, 64'h0F1E_2D3C_4B5A_6978,
             64'hA5A5_5A5A_C3C3_3C3C, 3, 1, 1, 0, -1);

    // Stray read beats while idle must not start or disturb anything.
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 16'hBAD0 + 16'(i);
      step();
      check("stray_busy", 64'(busy), 64'd0);
      check("stray_fill", 64'(fill_we), 64'd0);
    end
    mem_rvalid = 1'b0;
    run_miss(32'h0000_0208, 1'b0, 1'b1, 1'b0, 23'h7, 64'h1,
             64'h0102_0304_0506_0708, 0, 0, 0, 0, CLEAN_FILL);

    // Miss held during busy: second miss accepted right after FILL.
    nx_addr = 32'hFFFF_FFF8; nx_way = 1'b1; nx_valid = 1'b1; nx_dirty = 1'b1;
    nx_vtag = 23'h555555; nx_vdata = 64'h1357_9BDF_2468_ACE0;
    run_miss(32'h8000_0040, 1'b0, 1'b1, 1'b0, 23'h1, 64'h2,
             64'h9999_8888_7777_6666, 0, 0, 0, 1, CLEAN_FILL);
    check("held_miss_ready", 64'(miss_ready), 64'd1);
    run_miss(nx_addr, nx_way, nx_valid, nx_dirty, nx_vtag, nx_vdata,
             64'hCAFE_F00D_BEEF_FACE, 0, 0, 0, 0, DIRTY_FILL);

    // Reset after two read beats: no fill, controller idle, then a clean miss.
    sb_q.push_back('{EV_REQ, {31'd0, 1'b0, 23'h00000D, 6'd9, 3'b000}, 64'd0});
    miss_valid = 1'b1; miss_addr = 32'h0000_1A48; victim_way = 1'b0; victim_valid = 1'b0;
    step();
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
    step();
    check("rst_mid_busy", 64'(busy), 64'd1);
    mem_rdata = 16'h2222;
    step();
    mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(miss_ready), 64'd1);
    check("rst_mid_idle", 64'(busy), 64'd0);
    check("rst_mid_req", 64'(mem_req_valid), 64'd0);
    check("rst_mid_fill", 64'(fill_we), 64'd0);
    sb_q.delete();
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_hold_fill", 64'(fill_we), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle", 64'({busy, fill_we}), 64'd0);
    end
    run_miss(32'h0000_1A48, 1'b0, 1'b0, 1'b0, 23'h0, 64'h0,
             64'h0BAD_F00D_1234_5678, 0, 0, 0, 0, CLEAN_FILL);

    // A few randomized misses with random backpressure.
    for (int i = 0; i < 4; i++) begin
      run_miss($urandom, 1'($urandom), 1'($urandom), 1'($urandom), TAG_W'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom},
               int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 0, -1);
    end

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
